// File: rtl/clint_pkg.sv
// Shared CLINT register map, scheduler state encoding and address helper
// used by the CLINT bus masters.
package clint_pkg;

  localparam logic [15:0] MSIP_BASE     = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] MTIME_BASE    = 16'hbff8;

  localparam logic [63:0] TIME_NEVER = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    SCAN,
    WR_LO_MAX,
    WR_HI,
    WR_LO,
    SETTLE,
    WAIT
  } sched_state_e;

  // Byte address of the low word of mtimecmp for a given hart.
  function automatic logic [31:0] mtimecmp_addr(input int unsigned hart);
    return {16'h0000, MTIMECMP_BASE} + (hart << 3);
  endfunction

endpackage

// File: rtl/clint_wr_master.sv
// Single-outstanding CLINT write port: the request is presented while start_i
// is held and completes (done_o) on the cycle the slave accepts it.
module clint_wr_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   data_i,
  output logic                done_o,
  output logic                m_valid_o,
  output logic [ADDR_W-1:0]   m_address_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  output logic [DATA_W/8-1:0] m_wstrb_o,
  input  logic                m_ready_i
);

  // The caller keeps start_i, addr_i and data_i stable until done_o, so the
  // bus fields are stable for the whole handshake and idle at zero otherwise.
  assign m_valid_o   = start_i;
  assign m_address_o = start_i ? addr_i : '0;
  assign m_wdata_o   = start_i ? data_i : '0;
  assign m_wstrb_o   = start_i ? '1 : '0;
  assign done_o      = start_i & m_ready_i;

endmodule

// File: rtl/clint_timer_sched.sv
// Per-hart timer-event scheduler: keeps N_SLOTS deadlines, programs mtimecmp
// with the earliest active one and pulses expired[] when mtip fires.
module clint_timer_sched
  import clint_pkg::*;
#(
  parameter int unsigned N_SLOTS = 4,
  parameter int unsigned HART_ID = 0,
  parameter int          ADDR_W  = 32,
  parameter int          DATA_W  = 32,
  parameter int          SLOT_W  = $clog2(N_SLOTS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                arm_valid,
  input  logic [SLOT_W-1:0]   arm_slot,
  input  logic [63:0]         arm_deadline,
  input  logic                cancel_valid,
  input  logic [SLOT_W-1:0]   cancel_slot,
  output logic                req_ready,
  output logic [N_SLOTS-1:0]  active,
  output logic [N_SLOTS-1:0]  expired,
  input  logic                mtip,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_ready
);

  localparam logic [ADDR_W-1:0] CMP_LO    = ADDR_W'(mtimecmp_addr(HART_ID));
  localparam logic [ADDR_W-1:0] CMP_HI    = CMP_LO + ADDR_W'(4);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_SLOTS - 1);

  sched_state_e        state_q, state_d;
  logic [SLOT_W-1:0]   scan_idx_q, scan_idx_d;
  logic [N_SLOTS-1:0]  active_q, active_d;
  logic [N_SLOTS-1:0]  expired_q, expired_d;
  logic                cur_valid_q, cur_valid_d;
  logic [SLOT_W-1:0]   cur_slot_q, cur_slot_d;
  logic [63:0]         cur_dl_q, cur_dl_d;
  logic                settle_q, settle_d;
  logic [63:0]         dl_q [N_SLOTS];
  logic                dl_we;
  logic [63:0]         target;
  logic                wr_start, wr_done;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;

  assign target  = cur_valid_q ? cur_dl_q : TIME_NEVER;
  assign active  = active_q;
  assign expired = expired_q;

  always_comb begin
    state_d     = state_q;
    scan_idx_d  = scan_idx_q;
    active_d    = active_q;
    expired_d   = '0;
    cur_valid_d = cur_valid_q;
    cur_slot_d  = cur_slot_q;
    cur_dl_d    = cur_dl_q;
    settle_d    = settle_q;
    dl_we       = 1'b0;
    req_ready   = 1'b0;
    wr_start    = 1'b0;
    wr_addr     = CMP_LO;
    wr_data     = '1;
    unique case (state_q)
      SCAN: begin
        // Slot 0 seeds the running minimum; strict < keeps ties on the lower index.
        if (scan_idx_q == '0) begin
          cur_valid_d = active_q[0];
          cur_dl_d    = dl_q[0];
          cur_slot_d  = '0;
        end else if (active_q[scan_idx_q] &&
                     (!cur_valid_q || dl_q[scan_idx_q] < cur_dl_q)) begin
          cur_valid_d = 1'b1;
          cur_dl_d    = dl_q[scan_idx_q];
          cur_slot_d  = scan_idx_q;
        end
        if (scan_idx_q == LAST_SLOT) begin
          scan_idx_d = '0;
          state_d    = WR_LO_MAX;
        end else begin
          scan_idx_d = scan_idx_q + 1'b1;
        end
      end
      // Parking the low word at all-ones first keeps mtimecmp from passing
      // through a transient smaller value while the high word changes.
      WR_LO_MAX: begin
        wr_start = 1'b1;
        wr_addr  = CMP_LO;
        wr_data  = '1;
        if (wr_done) state_d = WR_HI;
      end
      WR_HI: begin
        wr_start = 1'b1;
        wr_addr  = CMP_HI;
        wr_data  = target[63:32];
        if (wr_done) state_d = WR_LO;
      end
      WR_LO: begin
        wr_start = 1'b1;
        wr_addr  = CMP_LO;
        wr_data  = target[31:0];
        if (wr_done) begin
          settle_d = 1'b0;
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q) state_d = WAIT;
        else          settle_d = 1'b1;
      end
      WAIT: begin
        if (mtip && cur_valid_q) begin
          expired_d[cur_slot_q] = 1'b1;
          active_d[cur_slot_q]  = 1'b0;
          state_d               = SCAN;
        end else begin
          req_ready = 1'b1;
          // Cancel is applied first so an arm of the same slot overrides it.
          if (cancel_valid) active_d[cancel_slot] = 1'b0;
          if (arm_valid) begin
            active_d[arm_slot] = 1'b1;
            dl_we              = 1'b1;
          end
          if (arm_valid || cancel_valid) state_d = SCAN;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= SCAN;
      scan_idx_q  <= '0;
      active_q    <= '0;
      expired_q   <= '0;
      cur_valid_q <= 1'b0;
      cur_slot_q  <= '0;
      settle_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_idx_q  <= scan_idx_d;
      active_q    <= active_d;
      expired_q   <= expired_d;
      cur_valid_q <= cur_valid_d;
      cur_slot_q  <= cur_slot_d;
      settle_q    <= settle_d;
    end
  end

  // Deadline storage is qualified by active_q, so it needs no reset.
  always_ff @(posedge clk) begin
    cur_dl_q <= cur_dl_d;
    if (dl_we) dl_q[arm_slot] <= arm_deadline;
  end

  clint_wr_master #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_wr (
    .start_i    (wr_start),
    .addr_i     (wr_addr),
    .data_i     (wr_data),
    .done_o     (wr_done),
    .m_valid_o  (m_valid),
    .m_address_o(m_address),
    .m_wdata_o  (m_wdata),
    .m_wstrb_o  (m_wstrb),
    .m_ready_i  (m_ready)
  );

endmodule
